// File: rtl/kb_pkg.sv
// Shared keyboard definitions: set-2 scan codes, ASCII control characters,
// the PS/2 frame layout and the frame acceptance check.
package kb_pkg;

  localparam logic [7:0] SC_SHIFT = 8'h12;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_CAPS  = 8'h58;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_TAB   = 8'h0D;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [7:0] ASCII_NUL   = 8'h00;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // First ten bits of a frame as they sit in the receive shift register
  // (start bit arrives first and ends up in the LSB).
  typedef struct packed {
    logic       parity;
    logic [7:0] data;
    logic       start;
  } ps2_frame_t;

  function automatic logic frame_ok(input ps2_frame_t f, input logic stop_bit,
                                    input logic check_parity);
    return !f.start && stop_bit && (!check_parity || (^{f.data, f.parity}));
  endfunction

endpackage

// File: rtl/kb2ascii_lut.sv
// Registered set-2 scan-code to ASCII translation honouring shift and
// caps-lock; unmapped codes produce 0x00.
module kb2ascii_lut
  import kb_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] code_in,
  input  logic       is_shift,
  input  logic       is_capital,
  output logic [7:0] ascii
);

  logic [7:0] ascii_d, ascii_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    ascii_d = ASCII_NUL;
    case (code_in)
      8'h1C: ascii_d = 8'h61;  8'h32: ascii_d = 8'h62;  8'h21: ascii_d = 8'h63;
      8'h23: ascii_d = 8'h64;  8'h24: ascii_d = 8'h65;  8'h2B: ascii_d = 8'h66;
      8'h34: ascii_d = 8'h67;  8'h33: ascii_d = 8'h68;  8'h43: ascii_d = 8'h69;
      8'h3B: ascii_d = 8'h6A;  8'h42: ascii_d = 8'h6B;  8'h4B: ascii_d = 8'h6C;
      8'h3A: ascii_d = 8'h6D;  8'h31: ascii_d = 8'h6E;  8'h44: ascii_d = 8'h6F;
      8'h4D: ascii_d = 8'h70;  8'h15: ascii_d = 8'h71;  8'h2D: ascii_d = 8'h72;
      8'h1B: ascii_d = 8'h73;  8'h2C: ascii_d = 8'h74;  8'h3C: ascii_d = 8'h75;
      8'h2A: ascii_d = 8'h76;  8'h1D: ascii_d = 8'h77;  8'h22: ascii_d = 8'h78;
      8'h35: ascii_d = 8'h79;  8'h1A: ascii_d = 8'h7A;
      8'h45: ascii_d = is_shift ? 8'h29 : 8'h30;
      8'h16: ascii_d = is_shift ? 8'h21 : 8'h31;
      8'h1E: ascii_d = is_shift ? 8'h40 : 8'h32;
      8'h26: ascii_d = is_shift ? 8'h23 : 8'h33;
      8'h25: ascii_d = is_shift ? 8'h24 : 8'h34;
      8'h2E: ascii_d = is_shift ? 8'h25 : 8'h35;
      8'h36: ascii_d = is_shift ? 8'h5E : 8'h36;
      8'h3D: ascii_d = is_shift ? 8'h26 : 8'h37;
      8'h3E: ascii_d = is_shift ? 8'h2A : 8'h38;
      8'h46: ascii_d = is_shift ? 8'h28 : 8'h39;
      8'h0E: ascii_d = is_shift ? 8'h7E : 8'h60;
      8'h4E: ascii_d = is_shift ? 8'h5F : 8'h2D;
      8'h55: ascii_d = is_shift ? 8'h2B : 8'h3D;
      8'h54: ascii_d = is_shift ? 8'h7B : 8'h5B;
      8'h5B: ascii_d = is_shift ? 8'h7D : 8'h5D;
      8'h5D: ascii_d = is_shift ? 8'h7C : 8'h5C;
      8'h4C: ascii_d = is_shift ? 8'h3A : 8'h3B;
      8'h52: ascii_d = is_shift ? 8'h22 : 8'h27;
      8'h41: ascii_d = is_shift ? 8'h3C : 8'h2C;
      8'h49: ascii_d = is_shift ? 8'h3E : 8'h2E;
      8'h4A: ascii_d = is_shift ? 8'h3F : 8'h2F;
      SC_SPACE: ascii_d = ASCII_SPACE;
      SC_ENTER: ascii_d = ASCII_CR;
      SC_BKSP:  ascii_d = ASCII_BS;
      SC_TAB:   ascii_d = ASCII_TAB;
      SC_ESC:   ascii_d = ASCII_ESC;
      default:  ascii_d = ASCII_NUL;
    endcase
    // Only the letter rows produce a..z, so the case fold can key off the value.
    if (ascii_d >= 8'h61 && ascii_d <= 8'h7A && (is_capital ^ is_shift))
      ascii_d = ascii_d - 8'h20;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) ascii_q <= ASCII_NUL;
    else       ascii_q <= ascii_d;
  end

  assign ascii = ascii_q;

endmodule

// File: rtl/ps2_kb2ascii.sv
// PS/2 receiver, scan-code FIFO with ready/nextdata_n pop and ASCII lookup.
// Define PS2_PARITY_CHECK_EN to also reject frames with bad odd parity.
module ps2_kb2ascii
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       ready,
  input  logic       nextdata_n,
  output logic       overflow,
  input  logic [7:0] code_in,
  input  logic       is_shift,
  input  logic       is_capital,
  output logic [7:0] ascii
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef PS2_PARITY_CHECK_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic [AW-1:0]          w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             mem [FIFO_DEPTH];

  logic       ps2_clk_s, ps2_dat_s, fall, push_req, push, pop, full;
  ps2_frame_t frame;

  assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
  assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
  assign frame     = ps2_frame_t'(shift_q);
  assign ready     = (r_ptr_q != w_ptr_q);
  assign full      = ((w_ptr_q + AW'(1)) == r_ptr_q);
  assign pop       = !nextdata_n && ready;
  assign push      = push_req && !full;
  assign data      = ready ? mem[r_ptr_q] : 8'h00;
  assign overflow  = overflow_q;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
    clk_prev_d = ps2_clk_s;
    fall       = clk_prev_q && !ps2_clk_s;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push_req   = 1'b0;
    if (fall) begin
      if (bit_cnt_q == 4'd10) begin
        // Stop bit is taken live; the other ten bits are already shifted in.
        bit_cnt_d = 4'd0;
        push_req  = frame_ok(frame, ps2_dat_s, PARITY_EN);
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {ps2_dat_s, shift_q[9:1]};
      end
    end
    w_ptr_d    = push ? w_ptr_q + AW'(1) : w_ptr_q;
    r_ptr_d    = pop  ? r_ptr_q + AW'(1) : r_ptr_q;
    overflow_d = overflow_q || (push_req && full);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      w_ptr_q    <= '0;
      r_ptr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      w_ptr_q    <= w_ptr_d;
      r_ptr_q    <= r_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array is not reset; data is masked to 0x00 while empty.
  always_ff @(posedge clk) begin
    if (push) mem[w_ptr_q] <= frame.data;
  end

  kb2ascii_lut u_lut (
    .clk       (clk),
    .clrn      (clrn),
    .code_in   (code_in),
    .is_shift  (is_shift),
    .is_capital(is_capital),
    .ascii     (ascii)
  );

endmodule

// File: tb/tb_ps2_kb2ascii.sv
// Directed bench for ps2_kb2ascii: receive path, FIFO handshake, overflow,
// parity handling, mid-frame reset and the ASCII lookup.
`timescale 1ns/1ps
module tb_ps2_kb2ascii;

  localparam time HALF = 100ns;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       nextdata_n = 1'b1;
  logic       overflow;
  logic [7:0] code_in = 8'h00;
  logic       is_shift = 1'b0;
  logic       is_capital = 1'b0;
  logic [7:0] ascii;

  int tests_run = 0;
  int tests_failed = 0;

  always #10 clk = ~clk;

  ps2_kb2ascii dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .data      (data),
    .ready     (ready),
    .nextdata_n(nextdata_n),
    .overflow  (overflow),
    .code_in   (code_in),
    .is_shift  (is_shift),
    .is_capital(is_capital),
    .ascii     (ascii)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    #(HALF);
    ps2_clk = 1'b0;
    #(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check(tag, {7'd0, ready}, 8'h01);
  endtask

  task automatic pop();
    @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  task automatic lut(input string tag, input logic [7:0] c, input logic sh,
                     input logic cap, input logic [7:0] exp);
    @(negedge clk);
    code_in = c; is_shift = sh; is_capital = cap;
    @(negedge clk);
    check(tag, ascii, exp);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_b;
    repeat (3) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_ready", {7'd0, ready}, 8'h00);
    check("rst_overflow", {7'd0, overflow}, 8'h00);
    check("rst_ascii", ascii, 8'h00);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame then one-cycle pop
    send_frame(8'h1C);
    wait_ready("f1_ready");
    check("f1_data", data, 8'h1C);
    pop();
    check("f1_pop_empty", {7'd0, ready}, 8'h00);

    // Ordering across three frames
    send_frame(8'h1C);
    send_frame(8'hF0);
    send_frame(8'h1C);
    settle();
    check("seq_data0", data, 8'h1C);
    pop();
    check("seq_data1", data, 8'hF0);
    pop();
    check("seq_data2", data, 8'h1C);
    pop();
    check("seq_empty", {7'd0, ready}, 8'h00);

    // Overflow: eight frames into seven usable slots
    for (int i = 1; i <= 8; i++) send_frame(8'(i));
    settle();
    check("ovf_flag", {7'd0, overflow}, 8'h01);
    for (int i = 1; i <= 7; i++) begin
      exp_b = 8'(i);
      check($sformatf("ovf_pop%0d", i), data, exp_b);
      pop();
    end
    check("ovf_empty", {7'd0, ready}, 8'h00);
    check("ovf_sticky", {7'd0, overflow}, 8'h01);
    pulse_reset();
    check("ovf_cleared", {7'd0, overflow}, 8'h00);

    // Wrong parity bit
    send_bits(8'h1C, 1'b1, 11);
    settle();
`ifdef PS2_PARITY_CHECK_EN
    check("badpar_ready", {7'd0, ready}, 8'h00);
`else
    check("badpar_ready", {7'd0, ready}, 8'h01);
    check("badpar_data", data, 8'h1C);
    pop();
`endif

    // Frame with stop bit low is always discarded
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    settle();
    check("badstop_ready", {7'd0, ready}, 8'h00);

    // Reset in the middle of a frame, then a clean frame
    send_bits(8'h55, 1'b0, 5);
    pulse_reset();
    send_frame(8'h2D);
    wait_ready("midrst_ready");
    check("midrst_data", data, 8'h2D);
    pop();
    check("midrst_only_one", {7'd0, ready}, 8'h00);

    // ASCII lookup
    lut("lut_a", 8'h1C, 1'b0, 1'b0, 8'h61);
    lut("lut_A_caps", 8'h1C, 1'b0, 1'b1, 8'h41);
    lut("lut_a_caps_shift", 8'h1C, 1'b1, 1'b1, 8'h61);
    lut("lut_Z_shift", 8'h1A, 1'b1, 1'b0, 8'h5A);
    lut("lut_bang", 8'h16, 1'b1, 1'b0, 8'h21);
    lut("lut_1_caps", 8'h16, 1'b0, 1'b1, 8'h31);
    lut("lut_lparen", 8'h46, 1'b1, 1'b0, 8'h28);
    lut("lut_underscore", 8'h4E, 1'b1, 1'b1, 8'h5F);
    lut("lut_backtick_caps", 8'h0E, 1'b0, 1'b1, 8'h60);
    lut("lut_question", 8'h4A, 1'b1, 1'b0, 8'h3F);
    lut("lut_enter", 8'h5A, 1'b1, 1'b1, 8'h0D);
    lut("lut_space", 8'h29, 1'b0, 1'b0, 8'h20);
    lut("lut_esc", 8'h76, 1'b0, 1'b0, 8'h1B);
    lut("lut_up", 8'h75, 1'b0, 1'b0, 8'h00);
    lut("lut_break", 8'hF0, 1'b1, 1'b0, 8'h00);
    lut("lut_zero", 8'h00, 1'b0, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
